// File: rtl/inst_loader.sv
// Boot loader: streams a word-count header plus big-endian words into instruction memory, then releases core reset.
// Build macro LOADER_CHECKSUM_EN adds a trailing sum word that must match the written data.

module inst_loader #(
    parameter int WORD      = 32,
    parameter int ADDR      = 32,
    parameter int MAX_WORDS = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      byte_i,
    input  logic            byte_v_i,
    output logic            byte_rdy_o,
    output logic            mem_sel_o,
    output logic [ADDR-1:0] mem_a_o,
    output logic            mem_w_o,
    output logic [WORD-1:0] mem_d_o,
    output logic            core_reset_o,
    output logic            done_o,
    output logic            err_o,
    output logic [ADDR-1:0] words_o
);

    // state  | meaning
    // S_LEN  | collecting the 4-byte word-count header
    // S_DATA | collecting program words, one memory write per word
    // S_SUM  | collecting the checksum trailer (checksum build only)
    // S_DONE | program loaded, core released (terminal)
    // S_ERR  | bad length or checksum, core held in reset (terminal)
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_LEN, S_DATA, S_SUM, S_DONE, S_ERR} state_t;
    localparam state_t S_AFTER_DATA = S_SUM;
`else
    typedef enum logic [2:0] {S_LEN, S_DATA, S_DONE, S_ERR} state_t;
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    state_t          state_q, state_d;
    logic            rdy_en_q;
    logic [1:0]      lane_q;
    logic [WORD-9:0] asm_q;
    logic [ADDR-1:0] len_q;
    logic            xfer;
    logic            word_done;
    logic            all_written;
    logic [WORD-1:0] word_full;

    assign xfer        = byte_v_i & byte_rdy_o;
    assign word_done   = xfer & (lane_q == 2'd3);
    assign word_full   = {asm_q, byte_i};
    assign all_written = (words_o == len_q);

    assign mem_sel_o    = (state_q != S_DONE);
    assign done_o       = (state_q == S_DONE);
    assign err_o        = (state_q == S_ERR);
    assign core_reset_o = done_o;

`ifdef LOADER_CHECKSUM_EN
    logic [WORD-1:0] sum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else if (word_done && state_q == S_DATA) begin
            sum_q <= sum_q + word_full;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LEN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_rdy_o = 1'b0;
        unique case (state_q)
            S_LEN: begin
                byte_rdy_o = rdy_en_q;
                if (word_done) begin
                    if (word_full == '0) begin
                        state_d = S_AFTER_DATA;
                    end else if (word_full > WORD'(MAX_WORDS)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                byte_rdy_o = rdy_en_q;
`else
                // stop accepting once the last word is in flight so nothing slips in before S_DONE
                byte_rdy_o = rdy_en_q & ~all_written;
`endif
                if (mem_w_o && all_written) begin
                    state_d = S_AFTER_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_SUM: begin
                byte_rdy_o = rdy_en_q;
                if (word_done) begin
                    state_d = (word_full == sum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_en_q <= 1'b0;
            lane_q   <= '0;
            asm_q    <= '0;
            len_q    <= '0;
            mem_w_o  <= 1'b0;
            mem_a_o  <= '0;
            mem_d_o  <= '0;
            words_o  <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            mem_w_o  <= 1'b0;
            if (xfer) begin
                lane_q <= lane_q + 2'd1;
                asm_q  <= word_full[WORD-9:0];
            end
            if (word_done && state_q == S_LEN) begin
                len_q <= ADDR'(word_full);
            end
            if (word_done && state_q == S_DATA) begin
                mem_w_o <= 1'b1;
                mem_a_o <= words_o;
                mem_d_o <= word_full;
                words_o <= words_o + ADDR'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader; define LOADER_CHECKSUM_EN to exercise the checksum build.

module tb_inst_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_v_i = 1'b0;
    logic        byte_rdy_o, mem_sel_o, mem_w_o, core_reset_o, done_o, err_o;
    logic [31:0] mem_a_o, mem_d_o, words_o;

    int n_cmp = 0;
    int n_bad = 0;
    int nw = 0;
    int ncyc = 0;
    int w_cyc = -1;
    int done_cyc = -1;
    int last_xfer = 0;
    logic [31:0] wa [16];
    logic [31:0] wd [16];

    inst_loader #(.WORD(32), .ADDR(32), .MAX_WORDS(1024)) dut (
        .clk(clk), .reset(reset), .byte_i(byte_i), .byte_v_i(byte_v_i),
        .byte_rdy_o(byte_rdy_o), .mem_sel_o(mem_sel_o), .mem_a_o(mem_a_o),
        .mem_w_o(mem_w_o), .mem_d_o(mem_d_o), .core_reset_o(core_reset_o),
        .done_o(done_o), .err_o(err_o), .words_o(words_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_w_o) begin
            if (nw < 16) begin
                wa[nw] = mem_a_o;
                wd[nw] = mem_d_o;
            end
            nw++;
            w_cyc = ncyc;
        end
        if (core_reset_o && done_cyc < 0) done_cyc = ncyc;
        ncyc++;
    end

    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            byte_i = b;
            byte_v_i = 1'b1;
            if (byte_rdy_o) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        if (ok) last_xfer = ncyc;
        #1 byte_v_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        bit ok;
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8], ok);
            if (!ok) begin
                n_cmp++; n_bad++;
                $display("FAIL byte_accept_timeout word %h lane %0d got rdy=0 exp rdy=1", w, i);
            end
        end
    endtask

    task automatic finish_load(input logic [31:0] sum);
`ifdef LOADER_CHECKSUM_EN
        send_word(sum);
`endif
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        #2 reset = 1'b0;
        byte_v_i = 1'b0;
        nw = 0;
        w_cyc = -1;
        done_cyc = -1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        n_cmp++; if (byte_rdy_o !== 1'b0)   begin n_bad++; $display("FAIL rst_rdy got %b exp 0", byte_rdy_o); end
        n_cmp++; if (mem_sel_o !== 1'b1)    begin n_bad++; $display("FAIL rst_sel got %b exp 1", mem_sel_o); end
        n_cmp++; if (mem_w_o !== 1'b0)      begin n_bad++; $display("FAIL rst_w got %b exp 0", mem_w_o); end
        n_cmp++; if (mem_a_o !== 32'h0)     begin n_bad++; $display("FAIL rst_a got %h exp 0", mem_a_o); end
        n_cmp++; if (mem_d_o !== 32'h0)     begin n_bad++; $display("FAIL rst_d got %h exp 0", mem_d_o); end
        n_cmp++; if (core_reset_o !== 1'b0) begin n_bad++; $display("FAIL rst_core got %b exp 0", core_reset_o); end
        n_cmp++; if (done_o !== 1'b0)       begin n_bad++; $display("FAIL rst_done got %b exp 0", done_o); end
        n_cmp++; if (err_o !== 1'b0)        begin n_bad++; $display("FAIL rst_err got %b exp 0", err_o); end
        n_cmp++; if (words_o !== 32'h0)     begin n_bad++; $display("FAIL rst_words got %h exp 0", words_o); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (byte_rdy_o !== 1'b0)   begin n_bad++; $display("FAIL rdy_before_edge got %b exp 0", byte_rdy_o); end
        @(posedge clk);
        #1;
        n_cmp++; if (byte_rdy_o !== 1'b1)   begin n_bad++; $display("FAIL rdy_after_edge got %b exp 1", byte_rdy_o); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        do_reset();
        send_word(32'h0000_0002);
        send_word(32'h1234_5678);
        send_word(32'h9ABC_DEF0);
        finish_load(32'hACF1_3568);
        n_cmp++; if (nw !== 2)                begin n_bad++; $display("FAIL b2b_nwrites got %0d exp 2", nw); end
        n_cmp++; if (wa[0] !== 32'h0)         begin n_bad++; $display("FAIL b2b_a0 got %h exp 0", wa[0]); end
        n_cmp++; if (wd[0] !== 32'h1234_5678) begin n_bad++; $display("FAIL b2b_d0 got %h exp 12345678", wd[0]); end
        n_cmp++; if (wa[1] !== 32'h1)         begin n_bad++; $display("FAIL b2b_a1 got %h exp 1", wa[1]); end
        n_cmp++; if (wd[1] !== 32'h9ABC_DEF0) begin n_bad++; $display("FAIL b2b_d1 got %h exp 9abcdef0", wd[1]); end
        n_cmp++; if (words_o !== 32'd2)       begin n_bad++; $display("FAIL b2b_words got %0d exp 2", words_o); end
        n_cmp++; if (done_o !== 1'b1)         begin n_bad++; $display("FAIL b2b_done got %b exp 1", done_o); end
        n_cmp++; if (err_o !== 1'b0)          begin n_bad++; $display("FAIL b2b_err got %b exp 0", err_o); end
        n_cmp++; if (core_reset_o !== 1'b1)   begin n_bad++; $display("FAIL b2b_core got %b exp 1", core_reset_o); end
        n_cmp++; if (mem_sel_o !== 1'b0)      begin n_bad++; $display("FAIL b2b_sel got %b exp 0", mem_sel_o); end
        n_cmp++; if (byte_rdy_o !== 1'b0)     begin n_bad++; $display("FAIL b2b_rdy got %b exp 0", byte_rdy_o); end
        n_cmp++; if (mem_a_o !== 32'h1 || mem_d_o !== 32'h9ABC_DEF0)
            begin n_bad++; $display("FAIL b2b_hold got %h/%h exp 1/9abcdef0", mem_a_o, mem_d_o); end
`ifdef LOADER_CHECKSUM_EN
        n_cmp++; if (done_cyc !== last_xfer)  begin n_bad++; $display("FAIL b2b_done_cycle got %0d exp %0d", done_cyc, last_xfer); end
`else
        n_cmp++; if (done_cyc !== w_cyc + 1)  begin n_bad++; $display("FAIL b2b_done_cycle got %0d exp %0d", done_cyc, w_cyc + 1); end
`endif
        send_byte(8'hAA, ok);
        n_cmp++; if (ok !== 1'b0)             begin n_bad++; $display("FAIL extra_byte_accepted got %b exp 0", ok); end
        n_cmp++; if (nw !== 2)                begin n_bad++; $display("FAIL extra_byte_nwrites got %0d exp 2", nw); end
    endtask

    task automatic test_zero_len;
        do_reset();
        send_word(32'h0000_0000);
`ifdef LOADER_CHECKSUM_EN
        n_cmp++; if (done_o !== 1'b0)        begin n_bad++; $display("FAIL zero_early_done got %b exp 0", done_o); end
        send_word(32'h0000_0000);
`endif
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (nw !== 0)               begin n_bad++; $display("FAIL zero_nwrites got %0d exp 0", nw); end
        n_cmp++; if (done_o !== 1'b1)        begin n_bad++; $display("FAIL zero_done got %b exp 1", done_o); end
        n_cmp++; if (core_reset_o !== 1'b1)  begin n_bad++; $display("FAIL zero_core got %b exp 1", core_reset_o); end
        n_cmp++; if (done_cyc !== last_xfer) begin n_bad++; $display("FAIL zero_done_cycle got %0d exp %0d", done_cyc, last_xfer); end
        n_cmp++; if (words_o !== 32'd0)      begin n_bad++; $display("FAIL zero_words got %0d exp 0", words_o); end
    endtask

    task automatic test_too_long;
        do_reset();
        send_word(32'h0000_0401);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (err_o !== 1'b1)        begin n_bad++; $display("FAIL long_err got %b exp 1", err_o); end
        n_cmp++; if (byte_rdy_o !== 1'b0)   begin n_bad++; $display("FAIL long_rdy got %b exp 0", byte_rdy_o); end
        n_cmp++; if (core_reset_o !== 1'b0) begin n_bad++; $display("FAIL long_core got %b exp 0", core_reset_o); end
        n_cmp++; if (done_o !== 1'b0)       begin n_bad++; $display("FAIL long_done got %b exp 0", done_o); end
        n_cmp++; if (mem_sel_o !== 1'b1)    begin n_bad++; $display("FAIL long_sel got %b exp 1", mem_sel_o); end
        n_cmp++; if (nw !== 0)              begin n_bad++; $display("FAIL long_nwrites got %0d exp 0", nw); end
    endtask

    task automatic test_wait_states;
        logic [31:0] w;
        bit ok;
        do_reset();
        send_word(32'h0000_0001);
        w = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            send_byte(w[31-8*i -: 8], ok);
            if (!ok) begin n_cmp++; n_bad++; $display("FAIL gap_byte_timeout lane %0d got rdy=0 exp rdy=1", i); end
            repeat (3) @(posedge clk);
            #1;
        end
        n_cmp++; if (nw !== 0)          begin n_bad++; $display("FAIL gap_early_write got %0d exp 0", nw); end
        n_cmp++; if (words_o !== 32'd0) begin n_bad++; $display("FAIL gap_early_words got %0d exp 0", words_o); end
        send_byte(w[7:0], ok);
        if (!ok) begin n_cmp++; n_bad++; $display("FAIL gap_byte_timeout lane 3 got rdy=0 exp rdy=1"); end
        finish_load(32'hDEAD_BEEF);
        n_cmp++; if (nw !== 1)                begin n_bad++; $display("FAIL gap_nwrites got %0d exp 1", nw); end
        n_cmp++; if (wa[0] !== 32'h0)         begin n_bad++; $display("FAIL gap_a0 got %h exp 0", wa[0]); end
        n_cmp++; if (wd[0] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL gap_d0 got %h exp deadbeef", wd[0]); end
        n_cmp++; if (done_o !== 1'b1)         begin n_bad++; $display("FAIL gap_done got %b exp 1", done_o); end
    endtask

    task automatic test_mid_reset;
        do_reset();
        send_word(32'h0000_0003);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (words_o !== 32'd2) begin n_bad++; $display("FAIL mid_pre_words got %0d exp 2", words_o); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (words_o !== 32'd0 || mem_a_o !== 32'h0 || mem_d_o !== 32'h0 || mem_w_o !== 1'b0)
            begin n_bad++; $display("FAIL mid_rst_mem got w=%0d a=%h d=%h we=%b exp 0/0/0/0", words_o, mem_a_o, mem_d_o, mem_w_o); end
        n_cmp++; if (byte_rdy_o !== 1'b0 || mem_sel_o !== 1'b1 || core_reset_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0)
            begin n_bad++; $display("FAIL mid_rst_ctl got rdy=%b sel=%b core=%b done=%b err=%b exp 0/1/0/0/0", byte_rdy_o, mem_sel_o, core_reset_o, done_o, err_o); end
        nw = 0;
        w_cyc = -1;
        done_cyc = -1;
        @(negedge clk);
        reset = 1'b1;
        send_word(32'h0000_0001);
        send_word(32'h55AA_55AA);
        finish_load(32'h55AA_55AA);
        n_cmp++; if (nw !== 1)                begin n_bad++; $display("FAIL mid_nwrites got %0d exp 1", nw); end
        n_cmp++; if (wa[0] !== 32'h0)         begin n_bad++; $display("FAIL mid_a0 got %h exp 0", wa[0]); end
        n_cmp++; if (wd[0] !== 32'h55AA_55AA) begin n_bad++; $display("FAIL mid_d0 got %h exp 55aa55aa", wd[0]); end
        n_cmp++; if (words_o !== 32'd1)       begin n_bad++; $display("FAIL mid_words got %0d exp 1", words_o); end
        n_cmp++; if (done_o !== 1'b1)         begin n_bad++; $display("FAIL mid_done got %b exp 1", done_o); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum;
        do_reset();
        send_word(32'h0000_0002);
        send_word(32'h0000_0001);
        send_word(32'h0000_0002);
        finish_load(32'h0000_0003);
        n_cmp++; if (done_o !== 1'b1 || err_o !== 1'b0)
            begin n_bad++; $display("FAIL sum_good got done=%b err=%b exp 1/0", done_o, err_o); end
        n_cmp++; if (nw !== 2) begin n_bad++; $display("FAIL sum_good_nwrites got %0d exp 2", nw); end
        do_reset();
        send_word(32'h0000_0002);
        send_word(32'h0000_0001);
        send_word(32'h0000_0002);
        finish_load(32'h0000_0004);
        n_cmp++; if (err_o !== 1'b1 || done_o !== 1'b0)
            begin n_bad++; $display("FAIL sum_bad got err=%b done=%b exp 1/0", err_o, done_o); end
        n_cmp++; if (core_reset_o !== 1'b0) begin n_bad++; $display("FAIL sum_bad_core got %b exp 0", core_reset_o); end
        n_cmp++; if (mem_sel_o !== 1'b1)    begin n_bad++; $display("FAIL sum_bad_sel got %b exp 1", mem_sel_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_zero_len();
        test_too_long();
        test_wait_states();
        test_mid_reset();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout got time=%0t exp finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
Boot-time writer for instruction memory; it is the write-side counterpart of the fetch stage's read port on mem_instruction.
- Accepts a byte stream (valid/ready) carrying a word-count header followed by program words.
- Assembles big-endian 32-bit words and writes them to consecutive word addresses from 0 via mem_instruction's A/W/D.
- Holds the core in reset until the program is fully written, then releases it.

Parameters:
WORD, 32, data word width (bits)
ADDR, 32, instruction memory address width (word addressed)
MAX_WORDS, 1024, largest accepted program length in words

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-low
byte_i  input  8  incoming stream byte
byte_v_i  input  1  byte_i valid
byte_rdy_o  output  1  loader ready; byte transferred at posedge when byte_v_i & byte_rdy_o
mem_sel_o  output  1  1 = loader owns mem_instruction A/W/D (top-level mux selects loader over fetch)
mem_a_o  output  ADDR  instruction memory word address
mem_w_o  output  1  instruction memory write strobe (one cycle per word)
mem_d_o  output  WORD  instruction memory write data
core_reset_o  output  1  active-low reset to fetch/decode/execute/register file
done_o  output  1  load completed successfully (sticky)
err_o  output  1  load failed (sticky)
words_o  output  ADDR  number of program words written so far

Behaviour:
- Reset (reset=0, async):
  - State = S_LEN; byte lane counter = 0; word counter = 0.
  - byte_rdy_o=0 while reset is asserted, 1 from the first clock edge after release.
  - mem_sel_o=1, mem_w_o=0, mem_a_o=0, mem_d_o=0, core_reset_o=0, done_o=0, err_o=0, words_o=0.
- Byte assembly:
  - Lane counter 0..3 advances on each transfer; the lane-0 byte lands in bits [31:24], lane 3 in [7:0].
  - The 4th transfer completes a word and the counter wraps to 0.
- FSM:
  - S_LEN: collect 4 bytes as length L.
    - L==0 -> S_DONE.
    - L>MAX_WORDS -> S_ERR.
    - Else -> S_DATA with remaining count = L.
  - S_DATA, on each completed word: in the next cycle mem_w_o=1 for exactly one cycle, mem_a_o=words_o (pre-increment value), mem_d_o=the assembled word. words_o increments in that same cycle.
    - byte_rdy_o stays 1 throughout, so 1 byte/cycle is sustained; a new word cannot complete while the previous write is pending.
    - After the L-th word -> S_DONE (or S_SUM if LOADER_CHECKSUM_EN).
  - S_DONE: byte_rdy_o=0, mem_sel_o=0, done_o=1, core_reset_o=1.
    - These take effect on the cycle after the final mem_w_o pulse, or the cycle after the 4th header byte when L==0.
    - Terminal until reset.
  - S_ERR: byte_rdy_o=0, err_o=1, core_reset_o=0, mem_sel_o=1, mem_w_o=0. Terminal until reset.
- Wait states:
  - Gaps in byte_v_i stall assembly with no side effect.
  - mem_a_o and mem_d_o hold their last values when mem_w_o=0.
- Extra bytes: bytes presented after S_DONE or S_ERR are never accepted (byte_rdy_o=0).
- Address arithmetic: words_o is unsigned, ADDR bits wide, and never exceeds MAX_WORDS.
- Reset mid-load:
  - All state returns to reset values and the next byte is treated as header lane 0.
  - Already-written memory words are left in place.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined:
  - The loader keeps a running sum (mod 2^32) of all data words written.
  - After the L-th data word, state S_SUM collects one more 4-byte word; this word is not written to memory.
  - Equal to the running sum -> S_DONE; unequal -> S_ERR.
  - With L==0 the S_SUM state is still entered and the expected sum is 0.
- Undefined: no S_SUM state, no sum register; S_DATA goes directly to S_DONE.

Test Plan:
- Header 00000002, words 12345678, 9ABCDEF0, bytes back-to-back -> mem_w_o pulses at A=0 D=12345678 and A=1 D=9ABCDEF0; words_o=2; core_reset_o rises the cycle after the 2nd pulse; done_o=1.
- Header 00000000 -> no mem_w_o; done_o=1 and core_reset_o=1 one cycle after the 4th byte (checksum build: requires trailer 00000000 first).
- Header 00000401 with MAX_WORDS=1024 -> err_o=1, byte_rdy_o=0, core_reset_o stays 0, no mem_w_o.
- Header 00000001, word DEADBEEF with byte_v_i low for 3 cycles between each byte -> single write A=0 D=DEADBEEF; no write before the 4th data byte.
- Assert reset after 2 of 3 words -> all outputs return to reset values; a subsequent full 1-word load writes A=0 and completes with words_o=1.
- LOADER_CHECKSUM_EN, header 2, words 00000001, 00000002: trailer 00000003 -> done_o=1; trailer 00000004 -> err_o=1 with core_reset_o=0.
